pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Generates per-register enable/flush and PC enable from cache hits, RAW hazards,
//  EX-stage redirects and halt. Sits beside the datapath; drives each pipe_reg_if
//  enable/flush pair. Also tracks halt-drain state and counts stall cycles.
// PARAMETERS
//  CNT_W     16  width of stall_cnt; the counter saturates at all ones
//  REG_W      5  register-select width
// PORTS
//  CLK          in   1      clock, posedge
//  nRST         in   1      reset, synchronous, active-low
//  ihit         in   1      instruction fetch complete this cycle
//  dhit         in   1      data access complete this cycle
//  mem_dREN     in   1      EX/MEM holds a load
//  mem_dWEN     in   1      EX/MEM holds a store
//  mem_halt     in   1      EX/MEM holds a halt instruction
//  ex_redirect  in   1      branch taken / jump / jr resolved in EX
//  id_rs        in   REG_W  IF/ID rs field
//  id_rt        in   REG_W  IF/ID rt field
//  id_uses_rt   in   1      IF/ID instruction reads rt
//  ex_wsel      in   REG_W  ID/EX destination register
//  ex_WEN       in   1      ID/EX writes the register file
//  ex_dREN      in   1      ID/EX is a load
//  mem_wsel     in   REG_W  EX/MEM destination register
//  mem_WEN      in   1      EX/MEM writes the register file
//  pc_en        out  1      PC update enable
//  ifid_en, idex_en, exmem_en, memwb_en              out 1  register capture enables
//  ifid_flush, idex_flush, exmem_flush, memwb_flush  out 1  load a bubble (all-zero)
//  halt         out  1      registered; processor halted
//  stall_cnt    out  CNT_W  registered; count of cycles with pc_en=0 in RUN
// BEHAVIOUR
//  FSM (registered): RUN -> DRAIN -> HALTED. Enables and flushes are combinational from the state and inputs.
//  Reset: state=RUN, halt=0, stall_cnt=0.
//   While nRST=0: all *_en=0, all *_flush=1, pc_en=0.
//  dwait = (mem_dREN|mem_dWEN) & ~dhit.
//  RUN priority (highest first); default is all en=1, all flush=0, pc_en=1:
//   1 dwait: all en=0, all flush=0, pc_en=0 (full freeze).
//   2 mem_halt: next=DRAIN; pc_en=0; ifid/idex/exmem flush=1; memwb_en=1.
//   3 ex_redirect: ifid_flush=1, idex_flush=1, pc_en=1 (PC loads target). Overrides hz.
//     If ~ihit as well: pc_en=1, the redirect takes effect, and fetch restarts.
//   4 hz (RAW hazard, see CONFIGURATION): pc_en=0, ifid_en=0, idex_flush=1. Later stages advance.
//   5 ~ihit: pc_en=0, ifid_flush=1. Later stages advance.
//  Register $0 never causes a hazard (wsel==0 is ignored).
//  DRAIN: pc_en=0; ifid/idex/exmem/memwb flush=1. The halt is written to MEM/WB.
//   One cycle later: next=HALTED.
//  HALTED: halt=1; all en=0; pc_en=0. Leaves this state only on reset. Inputs are ignored.
//  stall_cnt: +1 on each RUN cycle with pc_en=0 that is not in reset. Saturates at 2^CNT_W-1.
//   It holds its value in DRAIN and HALTED.
//  Reset mid-stall or mid-drain: everything returns to the reset state at the next posedge with nRST=0.
// CONFIGURATION
//  Macro PIPE_FORWARDING_EN.
//  Defined: hz = ex_dREN & ex_wsel!=0 & (ex_wsel==id_rs | id_uses_rt & ex_wsel==id_rt).
//   This is the load-use case only and stalls exactly 1 cycle.
//  Undefined: hz = the load-use case above, OR a match against any ex_WEN or mem_WEN destination
//   (same rs/rt compare, wsel!=0). A dependent stalls until its producer leaves EX/MEM:
//   2 cycles behind EX, 1 cycle behind MEM.
// TESTING
//  - Reset held 2 cycles, then nRST=1 with ihit=1 and no hazards
//    -> all en=1, flush=0, pc_en=1, stall_cnt=0.
//  - ex_dREN=1, ex_wsel=8, id_rs=8, ihit=1 (forwarding on)
//    -> 1 cycle with pc_en=0, ifid_en=0, idex_flush=1, then normal; stall_cnt=1.
//  - Forwarding off: ex_WEN=1, ex_wsel=9, id_rt=9, id_uses_rt=1
//    -> 2 stall cycles; the same case with ex_wsel=0 gives no stall.
//  - mem_dREN=1, dhit=0 for 3 cycles with ex_redirect=1
//    -> 3 cycles with all en=0; then dhit=1 gives ifid/idex flush=1, pc_en=1.
//  - mem_halt=1 -> DRAIN for 1 cycle, then HALTED. halt=1 stays set with ihit/dhit/hazard toggling.
//    nRST=0 for one cycle gives halt=0.
//  - Force 2^16+5 stall cycles -> stall_cnt=16'hFFFF (saturated, no wrap).

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: per-register enable/flush and PC enable for the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
// Latency: enables/flushes are combinational from state and inputs; halt and stall_cnt are registered (1 cycle).
// Backpressure: a pending data access freezes the whole pipe; RAW hazards and fetch misses stall the front end.
//
// Ports:
//   CLK, nRST                         clock (posedge) and synchronous active-low reset
//   ihit, dhit                        instruction fetch / data access complete this cycle
//   mem_dREN, mem_dWEN, mem_halt      EX/MEM holds a load / store / halt
//   ex_redirect                       branch/jump resolved in EX, PC loads the target
//   id_rs, id_rt, id_uses_rt          IF/ID source registers
//   ex_wsel, ex_WEN, ex_dREN          ID/EX destination, register write, load
//   mem_wsel, mem_WEN                 EX/MEM destination, register write
//   pc_en, *_en, *_flush              PC enable, register capture enables, bubble loads
//   halt, stall_cnt                   processor halted, saturating count of stalled RUN cycles
//
// Optional feature: define PIPE_FORWARDING_EN when the datapath forwards EX and MEM
// results; only the load-use case then needs a stall.

module pipeline_ctrl #(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_halt,
  input  logic             ex_redirect,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_wsel,
  input  logic             ex_WEN,
  input  logic             ex_dREN,
  input  logic [REG_W-1:0] mem_wsel,
  input  logic             mem_WEN,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             halt_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic dwait;
  logic ex_match;
  logic hz;

  // A data access still in flight blocks every stage.
  assign dwait = (mem_dREN | mem_dWEN) & ~dhit;

  // Register $0 is hardwired, so a write to it never creates a dependency.
  assign ex_match = (ex_wsel != '0) &
                    ((ex_wsel == id_rs) | (id_uses_rt & (ex_wsel == id_rt)));

`ifdef PIPE_FORWARDING_EN
  // Forwarding covers everything except a load whose data is not yet back.
  assign hz = ex_dREN & ex_match;
`else
  logic mem_match;
  assign mem_match = (mem_wsel != '0) &
                     ((mem_wsel == id_rs) | (id_uses_rt & (mem_wsel == id_rt)));
  // Without forwarding, the consumer waits until the producer has left EX/MEM.
  assign hz = ((ex_dREN | ex_WEN) & ex_match) | (mem_WEN & mem_match);
`endif

  // State register
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= ST_RUN;
      halt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      halt_q  <= (state_d == ST_HALTED);
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; a halt only advances once any pending data access completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (!dwait && mem_halt) state_d = ST_DRAIN;
      ST_DRAIN:  state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  // Output logic
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (dwait) begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
          memwb_en = 1'b0;
        end else if (mem_halt) begin
          // Let the halt reach MEM/WB, squash everything younger.
          pc_en       = 1'b0;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
        end else if (ex_redirect) begin
          // Redirect wins over a hazard: the dependent instruction is squashed anyway,
          // and the PC loads the target even if the current fetch missed.
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (hz) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end else if (!ihit) begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
        end
      end
      ST_DRAIN: begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        memwb_flush = 1'b1;
      end
      default: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
      end
    endcase

    // Reset forces bubbles into every register and holds the PC.
    if (!nRST) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end
  end

  // Stall counter: counts RUN cycles with the PC held, saturating at all ones.
  always_comb begin
    cnt_d = cnt_q;
    if (nRST && (state_q == ST_RUN) && !pc_en && (cnt_q != '1)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign halt      = halt_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: directed vector table, multi-cycle corner sequences,
// randomized stimulus against a reference model, and stall counter saturation.
// Honours PIPE_FORWARDING_EN the same way the design does.

module tb_pipeline_ctrl;

  localparam int CNT_W = 16;
  localparam int REG_W = 5;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic             nrst;
    logic             ihit;
    logic             dhit;
    logic             mem_dren;
    logic             mem_dwen;
    logic             mem_halt;
    logic             ex_redirect;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic [REG_W-1:0] ex_wsel;
    logic             ex_wen;
    logic             ex_dren;
    logic [REG_W-1:0] mem_wsel;
    logic             mem_wen;
  } in_t;

  typedef struct {
    string      nm;
    in_t        v;
    logic [8:0] exp;
  } vec_t;

  // Output vector order: {pc_en, ifid/idex/exmem/memwb en, ifid/idex/exmem/memwb flush}
  localparam logic [8:0] O_NORM   = 9'b1_1111_0000;
  localparam logic [8:0] O_RST    = 9'b0_0000_1111;
  localparam logic [8:0] O_FREEZE = 9'b0_0000_0000;
  localparam logic [8:0] O_HALT   = 9'b0_1111_1110;
  localparam logic [8:0] O_REDIR  = 9'b1_1111_1100;
  localparam logic [8:0] O_HZ     = 9'b0_0111_0100;
  localparam logic [8:0] O_MISS   = 9'b0_1111_1000;

  in_t cur;

  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic             halt;
  logic [CNT_W-1:0] stall_cnt;
  logic [8:0]       got_out;

  assign got_out = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                    ifid_flush, idex_flush, exmem_flush, memwb_flush};

  pipeline_ctrl #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
    .CLK         (CLK),
    .nRST        (cur.nrst),
    .ihit        (cur.ihit),
    .dhit        (cur.dhit),
    .mem_dREN    (cur.mem_dren),
    .mem_dWEN    (cur.mem_dwen),
    .mem_halt    (cur.mem_halt),
    .ex_redirect (cur.ex_redirect),
    .id_rs       (cur.id_rs),
    .id_rt       (cur.id_rt),
    .id_uses_rt  (cur.id_uses_rt),
    .ex_wsel     (cur.ex_wsel),
    .ex_WEN      (cur.ex_wen),
    .ex_dREN     (cur.ex_dren),
    .mem_wsel    (cur.mem_wsel),
    .mem_WEN     (cur.mem_wen),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .idex_en     (idex_en),
    .exmem_en    (exmem_en),
    .memwb_en    (memwb_en),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .exmem_flush (exmem_flush),
    .memwb_flush (memwb_flush),
    .halt        (halt),
    .stall_cnt   (stall_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 = running, 1 = draining, 2 = halted.
  int          m_phase = 0;
  logic        m_halt  = 1'b0;
  int unsigned m_cnt   = 0;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic depends(input in_t v, input logic [REG_W-1:0] wsel);
    return (wsel != 0) && (wsel == v.id_rs || (v.id_uses_rt && wsel == v.id_rt));
  endfunction

  function automatic logic m_hz(input in_t v);
    logic load_use;
    load_use = v.ex_dren && depends(v, v.ex_wsel);
`ifdef PIPE_FORWARDING_EN
    return load_use;
`else
    return load_use || (v.ex_wen && depends(v, v.ex_wsel)) || (v.mem_wen && depends(v, v.mem_wsel));
`endif
  endfunction

  function automatic logic [8:0] m_out(input int phase, input in_t v);
    if (!v.nrst)                              return O_RST;
    if (phase == 2)                           return O_FREEZE;
    if (phase == 1)                           return O_RST;
    if ((v.mem_dren || v.mem_dwen) && !v.dhit) return O_FREEZE;
    if (v.mem_halt)                           return O_HALT;
    if (v.ex_redirect)                        return O_REDIR;
    if (m_hz(v))                              return O_HZ;
    if (!v.ihit)                              return O_MISS;
    return O_NORM;
  endfunction

  task automatic model_step(input in_t v);
    logic [8:0] o;
    logic       dw;
    o  = m_out(m_phase, v);
    dw = (v.mem_dren || v.mem_dwen) && !v.dhit;
    if (!v.nrst) begin
      m_phase = 0;
      m_cnt   = 0;
    end else if (m_phase == 0) begin
      if (!o[8] && m_cnt < CNT_MAX) m_cnt++;
      if (v.mem_halt && !dw) m_phase = 1;
    end else begin
      m_phase = 2;
    end
    m_halt = (m_phase == 2);
  endtask

  // Entered at posedge+1; drives, checks comb outputs mid-cycle, then registered ones after the edge.
  task automatic run_cycle(input in_t v, input logic [8:0] exp, input string nm);
    cur = v;
    #4;
    chk(nm, {23'd0, got_out}, {23'd0, exp});
    model_step(v);
    @(posedge CLK);
    #1;
    chk({nm, "_halt"}, {31'd0, halt}, {31'd0, m_halt});
    chk({nm, "_cnt"}, {16'd0, stall_cnt}, m_cnt);
  endtask

  task automatic add(input string nm, input in_t v, input logic [8:0] exp);
    vec_t e;
    e.nm = nm; e.v = v; e.exp = exp;
    tbl.push_back(e);
  endtask

  initial begin
    in_t idle, rst, v;
    int unsigned base;

    idle = '0; idle.nrst = 1'b1; idle.ihit = 1'b1;
    rst  = idle; rst.nrst = 1'b0;

    // ---- directed table (all in RUN, no halts) ----
    add("idle", idle, O_NORM);
    v = idle; v.ex_dren = 1; v.ex_wen = 1; v.ex_wsel = 8; v.id_rs = 8;           add("loaduse_rs", v, O_HZ);
    v = idle; v.ex_dren = 1; v.ex_wsel = 8; v.id_rs = 3; v.id_rt = 8;            add("rt_unused", v, O_NORM);
    v.id_uses_rt = 1;                                                           add("loaduse_rt", v, O_HZ);
    v = idle; v.ex_dren = 1; v.ex_wen = 1; v.ex_wsel = 0; v.id_rs = 0;           add("reg0", v, O_NORM);
    v = idle; v.ihit = 0;                                                       add("imiss", v, O_MISS);
    v = idle; v.ihit = 0; v.ex_dren = 1; v.ex_wsel = 4; v.id_rs = 4;             add("hz_over_miss", v, O_HZ);
    v = idle; v.ex_redirect = 1; v.ex_dren = 1; v.ex_wsel = 4; v.id_rs = 4;      add("redir_over_hz", v, O_REDIR);
    v = idle; v.ex_redirect = 1; v.ihit = 0;                                    add("redir_miss", v, O_REDIR);
    v = idle; v.mem_dren = 1;                                                   add("dwait_load", v, O_FREEZE);
    v = idle; v.mem_dwen = 1; v.ex_redirect = 1;                                add("dwait_store", v, O_FREEZE);
    v = idle; v.mem_dren = 1; v.mem_halt = 1;                                   add("dwait_over_halt", v, O_FREEZE);
    v = idle; v.mem_dren = 1; v.dhit = 1; v.ex_redirect = 1;                    add("dhit_redir", v, O_REDIR);
    add("mid_reset", rst, O_RST);
    add("after_reset", idle, O_NORM);

    cur = rst;
    @(posedge CLK);
    #1;

    // ---- reset held two cycles, then release ----
    run_cycle(rst, O_RST, "reset0");
    run_cycle(rst, O_RST, "reset1");
    run_cycle(idle, O_NORM, "release");
    chk("release_cnt", {16'd0, stall_cnt}, 32'd0);

    foreach (tbl[i]) run_cycle(tbl[i].v, tbl[i].exp, tbl[i].nm);

    // ---- load-use: producer in EX, then in MEM, then gone ----
    base = m_cnt;
    v = idle; v.ex_dren = 1; v.ex_wen = 1; v.ex_wsel = 8; v.id_rs = 8;
    run_cycle(v, O_HZ, "lu_ex");
    v = idle; v.mem_dren = 1; v.dhit = 1; v.mem_wen = 1; v.mem_wsel = 8; v.id_rs = 8;
`ifdef PIPE_FORWARDING_EN
    run_cycle(v, O_NORM, "lu_mem");
`else
    run_cycle(v, O_HZ, "lu_mem");
`endif
    run_cycle(idle, O_NORM, "lu_done");
`ifdef PIPE_FORWARDING_EN
    chk("lu_stalls", {16'd0, stall_cnt}, base + 1);
`else
    chk("lu_stalls", {16'd0, stall_cnt}, base + 2);
`endif

    // ---- ALU producer on rt: 2 stalls without forwarding, none with it ----
    base = m_cnt;
    v = idle; v.ex_wen = 1; v.ex_wsel = 9; v.id_rt = 9; v.id_uses_rt = 1;
`ifdef PIPE_FORWARDING_EN
    run_cycle(v, O_NORM, "alu_ex");
`else
    run_cycle(v, O_HZ, "alu_ex");
`endif
    v = idle; v.mem_wen = 1; v.mem_wsel = 9; v.id_rt = 9; v.id_uses_rt = 1;
`ifdef PIPE_FORWARDING_EN
    run_cycle(v, O_NORM, "alu_mem");
    chk("alu_stalls", {16'd0, stall_cnt}, base);
`else
    run_cycle(v, O_HZ, "alu_mem");
    chk("alu_stalls", {16'd0, stall_cnt}, base + 2);
`endif
    base = m_cnt;
    v = idle; v.ex_wen = 1; v.ex_wsel = 0; v.id_rt = 0; v.id_uses_rt = 1;
    run_cycle(v, O_NORM, "alu_reg0");
    chk("alu_reg0_cnt", {16'd0, stall_cnt}, base);

    // ---- data wait with redirect pending ----
    base = m_cnt;
    v = idle; v.mem_dren = 1; v.ex_redirect = 1;
    for (int i = 0; i < 3; i++) run_cycle(v, O_FREEZE, "dwait_redir");
    v.dhit = 1;
    run_cycle(v, O_REDIR, "dwait_release");
    chk("dwait_cnt", {16'd0, stall_cnt}, base + 3);

    // ---- halt, drain, halted with toggling inputs, reset out ----
    v = idle; v.mem_halt = 1;
    run_cycle(v, O_HALT, "halt_run");
    chk("drain_halt_low", {31'd0, halt}, 32'd0);
    run_cycle(idle, O_RST, "drain");
    chk("halted_set", {31'd0, halt}, 32'd1);
    base = m_cnt;
    for (int i = 0; i < 4; i++) begin
      v = idle;
      v.ihit = i[0]; v.dhit = i[1]; v.mem_dren = ~i[0]; v.ex_redirect = i[1];
      v.ex_dren = 1; v.ex_wsel = 6; v.id_rs = 6; v.mem_halt = i[0];
      run_cycle(v, O_FREEZE, "halted");
    end
    chk("halted_held", {31'd0, halt}, 32'd1);
    chk("halted_cnt_hold", {16'd0, stall_cnt}, base);
    run_cycle(rst, O_RST, "halt_reset");
    chk("halt_cleared", {31'd0, halt}, 32'd0);
    run_cycle(idle, O_NORM, "post_halt");

    // ---- randomized against the model ----
    for (int n = 0; n < 3000; n++) begin
      v.nrst        = ($urandom_range(0, 99) >= 2);
      v.ihit        = ($urandom_range(0, 3) != 0);
      v.dhit        = $urandom_range(0, 1);
      v.mem_dren    = ($urandom_range(0, 4) == 0);
      v.mem_dwen    = ($urandom_range(0, 4) == 0);
      v.mem_halt    = ($urandom_range(0, 39) == 0);
      v.ex_redirect = ($urandom_range(0, 6) == 0);
      v.id_rs       = REG_W'($urandom_range(0, 3));
      v.id_rt       = REG_W'($urandom_range(0, 3));
      v.id_uses_rt  = $urandom_range(0, 1);
      v.ex_wsel     = REG_W'($urandom_range(0, 3));
      v.ex_wen      = $urandom_range(0, 1);
      v.ex_dren     = ($urandom_range(0, 2) == 0);
      v.mem_wsel    = REG_W'($urandom_range(0, 3));
      v.mem_wen     = $urandom_range(0, 1);
      run_cycle(v, m_out(m_phase, v), "rand");
    end

    // ---- saturation: 2^16+5 stalled cycles ----
    run_cycle(rst, O_RST, "sat_reset");
    v = idle; v.ihit = 0;
    cur = v;
    repeat ((1 << CNT_W) + 5) @(posedge CLK);
    #1;
    chk("sat_cnt", {16'd0, stall_cnt}, 32'h0000_FFFF);
    chk("sat_outputs", {23'd0, got_out}, {23'd0, O_MISS});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
